// File: rtl/wb_port_arbiter_pkg.sv
// wb_arb_pkg: shared types and constants for the register-file write-port arbiter.
//   arb_state_e  : arbiter FSM states (IDLE, WAIT, FORCE)
//   REG_ZERO     : hard-wired zero register address (writes to it are dropped)
//   BE_WORD      : full-word byte-enable mask used for long-latency writes
//   wb_sel_data  : WB-stage write-data mux (load data vs. ALU result)
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no long-latency request pending
        WAIT  = 2'd1,   // ll_req high, lost arbitration at least once
        FORCE = 2'd2    // requester starved: pipeline frozen, ll granted
    } arb_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [3:0] BE_WORD  = 4'hF;

    function automatic logic [31:0] wb_sel_data(input logic        memtoreg,
                                                input logic [31:0] dout,
                                                input logic [31:0] result);
        return memtoreg ? dout : result;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: bundles every non-clock/reset signal of the write-port arbiter.
//   WB stage  : wb_regwr, wb_be, wb_rw, wb_memtoreg, wb_dout, wb_result, wb_ovsel, wb_overflow
//   LL unit   : ll_req, ll_rw, ll_data -> ll_ack
//   Pipeline  : stall_pipe
//   RF port   : rf_we, rf_be, rf_waddr, rf_wdata, ovf_trap
//   Forwarding: id_rs, id_rt -> fwd_a, fwd_b (active only with WB_FWD_EN)
// Modports: slave = arbiter side, master = surrounding pipeline / testbench side.
interface wb_port_arbiter_if;

    logic        wb_regwr;
    logic [3:0]  wb_be;
    logic [4:0]  wb_rw;
    logic        wb_memtoreg;
    logic [31:0] wb_dout;
    logic [31:0] wb_result;
    logic        wb_ovsel;
    logic        wb_overflow;

    logic        ll_req;
    logic [4:0]  ll_rw;
    logic [31:0] ll_data;
    logic        ll_ack;

    logic        stall_pipe;

    logic        rf_we;
    logic [3:0]  rf_be;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ovf_trap;

    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        fwd_a;
    logic        fwd_b;

    modport slave (
        input  wb_regwr, wb_be, wb_rw, wb_memtoreg, wb_dout, wb_result, wb_ovsel, wb_overflow,
        input  ll_req, ll_rw, ll_data, id_rs, id_rt,
        output ll_ack, stall_pipe, rf_we, rf_be, rf_waddr, rf_wdata, ovf_trap, fwd_a, fwd_b
    );

    modport master (
        output wb_regwr, wb_be, wb_rw, wb_memtoreg, wb_dout, wb_result, wb_ovsel, wb_overflow,
        output ll_req, ll_rw, ll_data, id_rs, id_rt,
        input  ll_ack, stall_pipe, rf_we, rf_be, rf_waddr, rf_wdata, ovf_trap, fwd_a, fwd_b
    );

endinterface

// File: rtl/wb_port_arbiter_starve_ctr.sv
// wb_starve_ctr: counts how many consecutive cycles the long-latency requester lost
// arbitration to the WB stage.
//   clk, rst_n : clock, synchronous active-low reset
//   clr_i      : clear the count (has priority over inc_i)
//   inc_i      : one more lost cycle
//   hit_o      : the increment happening this cycle brings the count to MAX_WAIT
module wb_starve_ctr #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Look-ahead compare so the FSM can enter FORCE right after the MAX_WAIT-th loss.
    assign hit_o = inc_i && (({1'b0, cnt_q} + 5'd1) == 5'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: owns the register-file write port behind MEM/WB. Arbitrates between the
// in-order WB stage and an out-of-order long-latency unit, suppresses writes of trapping
// overflowed instructions, and freezes the pipeline when the long-latency unit starves.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : wb_port_arbiter_if.slave (WB inputs, LL handshake, stall, RF write port,
//                forwarding)
// Parameter MAX_WAIT (1..15): lost arbitrations tolerated before a forced grant.
// Build option WB_FWD_EN: enables fwd_a/fwd_b comparators; otherwise both are tied to 0.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    wb_port_arbiter_if.slave    bus
);

    arb_state_e  state_q, state_d;
    logic        rf_we_q;
    logic [3:0]  rf_be_q;
    logic [4:0]  rf_waddr_q;
    logic [31:0] rf_wdata_q;
    logic        ovf_trap_q;

    logic        wb_eff;
    logic [31:0] wb_data;
    logic        grant_wb, grant_ll, stall;
    logic        cnt_inc, cnt_clr, cnt_hit;
    logic        ll_wr;

    assign wb_eff  = bus.wb_regwr & (|bus.wb_be) & (bus.wb_rw != REG_ZERO)
                   & ~(bus.wb_ovsel & bus.wb_overflow);
    assign wb_data = wb_sel_data(bus.wb_memtoreg, bus.wb_dout, bus.wb_result);

    wb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .hit_o (cnt_hit)
    );

    always_comb begin
        state_d  = state_q;
        grant_wb = 1'b0;
        grant_ll = 1'b0;
        stall    = 1'b0;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        unique case (state_q)
            IDLE, WAIT: begin
                if (wb_eff) begin
                    grant_wb = 1'b1;
                    if (bus.ll_req) begin
                        cnt_inc = 1'b1;
                        state_d = cnt_hit ? FORCE : WAIT;
                    end else begin
                        // Nothing pending, or requester withdrew before its ack.
                        cnt_clr = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    grant_ll = bus.ll_req;
                    cnt_clr  = 1'b1;
                    state_d  = IDLE;
                end
            end
            FORCE: begin
                // MEM/WB is frozen, so the WB instruction re-presents next cycle.
                stall    = 1'b1;
                grant_ll = bus.ll_req;
                cnt_clr  = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
        // No handshake while reset is being sampled; the pending request is forgotten.
        if (!rst_n) begin
            grant_wb = 1'b0;
            grant_ll = 1'b0;
        end
    end

    assign ll_wr = grant_ll & (bus.ll_rw != REG_ZERO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rf_we_q    <= 1'b0;
            rf_be_q    <= '0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            ovf_trap_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rf_we_q <= grant_wb | ll_wr;
            if (grant_wb) begin
                rf_be_q    <= bus.wb_be;
                rf_waddr_q <= bus.wb_rw;
                rf_wdata_q <= wb_data;
            end else if (ll_wr) begin
                rf_be_q    <= BE_WORD;
                rf_waddr_q <= bus.ll_rw;
                rf_wdata_q <= bus.ll_data;
            end
            // Not raised in FORCE: the frozen instruction traps when it re-presents.
            ovf_trap_q <= (state_q != FORCE) & bus.wb_regwr & bus.wb_ovsel & bus.wb_overflow;
        end
    end

    assign bus.ll_ack     = grant_ll;
    assign bus.stall_pipe = stall;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_be      = rf_be_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.ovf_trap   = ovf_trap_q;

`ifdef WB_FWD_EN
    assign bus.fwd_a = rf_we_q & (rf_waddr_q == bus.id_rs) & (bus.id_rs != REG_ZERO);
    assign bus.fwd_b = rf_we_q & (rf_waddr_q == bus.id_rt) & (bus.id_rt != REG_ZERO);
`else
    logic unused_id;
    assign unused_id = ^{bus.id_rs, bus.id_rt};
    assign bus.fwd_a = 1'b0;
    assign bus.fwd_b = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed self-checking bench for wb_port_arbiter (MAX_WAIT=4).
// Inputs change 1 time unit after posedge; combinational outputs are checked 1 unit later,
// registered outputs 1 unit after the following posedge.
module tb_wb_port_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    wb_port_arbiter_if bus();

    wb_port_arbiter #(.MAX_WAIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.wb_regwr    = 1'b0;
        bus.wb_be       = 4'h0;
        bus.wb_rw       = 5'd0;
        bus.wb_memtoreg = 1'b0;
        bus.wb_dout     = 32'h0;
        bus.wb_result   = 32'h0;
        bus.wb_ovsel    = 1'b0;
        bus.wb_overflow = 1'b0;
        bus.ll_req      = 1'b0;
        bus.ll_rw       = 5'd0;
        bus.ll_data     = 32'h0;
        bus.id_rs       = 5'd0;
        bus.id_rt       = 5'd0;
    endtask

    task automatic wb_write(input logic [4:0] rw, input logic [31:0] res);
        bus.wb_regwr    = 1'b1;
        bus.wb_be       = 4'hF;
        bus.wb_rw       = rw;
        bus.wb_memtoreg = 1'b0;
        bus.wb_result   = res;
    endtask

    logic exp_fwd;

    initial begin
        checks = 0;
        errors = 0;
`ifdef WB_FWD_EN
        exp_fwd = 1'b1;
`else
        exp_fwd = 1'b0;
`endif
        clear_inputs();
        rst_n = 1'b0;
        cycle();
        cycle();
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_rf_be", 32'(bus.rf_be), 32'd0);
        chk("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
        chk("rst_ovf_trap", 32'(bus.ovf_trap), 32'd0);
        chk("rst_ll_ack", 32'(bus.ll_ack), 32'd0);
        chk("rst_stall", 32'(bus.stall_pipe), 32'd0);
        rst_n = 1'b1;

        // 1: WB load write, then ALU write with partial byte enables.
        bus.wb_regwr = 1'b1; bus.wb_be = 4'hF; bus.wb_rw = 5'd5;
        bus.wb_memtoreg = 1'b1; bus.wb_dout = 32'hDEAD_BEEF; bus.wb_result = 32'h1111_1111;
        #1 chk("t1_ll_ack", 32'(bus.ll_ack), 32'd0);
        cycle();
        chk("t1_rf_we", 32'(bus.rf_we), 32'd1);
        chk("t1_rf_waddr", 32'(bus.rf_waddr), 32'd5);
        chk("t1_rf_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
        chk("t1_rf_be", 32'(bus.rf_be), 32'hF);
        bus.wb_memtoreg = 1'b0; bus.wb_result = 32'hCAFE_0001; bus.wb_be = 4'h3; bus.wb_rw = 5'd6;
        cycle();
        chk("t1b_rf_wdata", bus.rf_wdata, 32'hCAFE_0001);
        chk("t1b_rf_be", 32'(bus.rf_be), 32'h3);
        clear_inputs();
        cycle();
        chk("idle_rf_we", 32'(bus.rf_we), 32'd0);
        chk("idle_hold_waddr", 32'(bus.rf_waddr), 32'd6);
        chk("idle_hold_wdata", bus.rf_wdata, 32'hCAFE_0001);

        // 2: long-latency write with WB idle.
        bus.ll_req = 1'b1; bus.ll_rw = 5'd9; bus.ll_data = 32'h0000_1234;
        #1 chk("t2_ll_ack", 32'(bus.ll_ack), 32'd1);
        chk("t2_stall", 32'(bus.stall_pipe), 32'd0);
        cycle();
        bus.ll_req = 1'b0;
        chk("t2_rf_we", 32'(bus.rf_we), 32'd1);
        chk("t2_rf_waddr", 32'(bus.rf_waddr), 32'd9);
        chk("t2_rf_wdata", bus.rf_wdata, 32'h0000_1234);
        chk("t2_rf_be", 32'(bus.rf_be), 32'hF);

        // 3: starvation -> four WB writes, then forced ll grant with stall.
        bus.ll_req = 1'b1; bus.ll_rw = 5'd10; bus.ll_data = 32'hAAAA_5555;
        for (int i = 0; i < 4; i++) begin
            wb_write(5'(i + 1), 32'(i + 32'h100));
            #1 chk("t3_ll_ack_wait", 32'(bus.ll_ack), 32'd0);
            chk("t3_stall_wait", 32'(bus.stall_pipe), 32'd0);
            cycle();
            chk("t3_wb_waddr", 32'(bus.rf_waddr), 32'(i + 1));
            chk("t3_wb_wdata", bus.rf_wdata, 32'(i + 32'h100));
        end
        #1 chk("t3_force_stall", 32'(bus.stall_pipe), 32'd1);
        chk("t3_force_ack", 32'(bus.ll_ack), 32'd1);
        cycle();
        bus.ll_req = 1'b0;
        chk("t3_force_we", 32'(bus.rf_we), 32'd1);
        chk("t3_force_waddr", 32'(bus.rf_waddr), 32'd10);
        chk("t3_force_wdata", bus.rf_wdata, 32'hAAAA_5555);
        chk("t3_force_be", 32'(bus.rf_be), 32'hF);
        #1 chk("t3_after_stall", 32'(bus.stall_pipe), 32'd0);
        cycle();
        chk("t3_after_waddr", 32'(bus.rf_waddr), 32'd4);

        // 4: overflow suppression, zero destination, non-overflow trap-enabled write, ll_rw=0.
        clear_inputs();
        wb_write(5'd3, 32'h3333_3333);
        bus.wb_ovsel = 1'b1; bus.wb_overflow = 1'b1;
        cycle();
        chk("t4_ovf_we", 32'(bus.rf_we), 32'd0);
        chk("t4_ovf_trap", 32'(bus.ovf_trap), 32'd1);
        clear_inputs();
        cycle();
        chk("t4_trap_pulse", 32'(bus.ovf_trap), 32'd0);
        wb_write(5'd0, 32'h0BAD_0BAD);
        cycle();
        chk("t4_rw0_we", 32'(bus.rf_we), 32'd0);
        wb_write(5'd8, 32'h8888_0000);
        bus.wb_ovsel = 1'b1; bus.wb_overflow = 1'b0;
        cycle();
        chk("t4_noovf_we", 32'(bus.rf_we), 32'd1);
        chk("t4_noovf_trap", 32'(bus.ovf_trap), 32'd0);
        clear_inputs();
        bus.ll_req = 1'b1; bus.ll_rw = 5'd0; bus.ll_data = 32'h5A5A_5A5A;
        #1 chk("t4_llz_ack", 32'(bus.ll_ack), 32'd1);
        cycle();
        bus.ll_req = 1'b0;
        chk("t4_llz_we", 32'(bus.rf_we), 32'd0);
        chk("t4_llz_hold", bus.rf_wdata, 32'h8888_0000);

        // 5: reset while in FORCE, then starvation count restarts from zero.
        bus.ll_req = 1'b1; bus.ll_rw = 5'd11; bus.ll_data = 32'h1111_0000;
        wb_write(5'd12, 32'hC0C0_C0C0);
        for (int i = 0; i < 4; i++) cycle();
        #1 chk("t5_in_force", 32'(bus.stall_pipe), 32'd1);
        rst_n = 1'b0;
        cycle();
        chk("t5_rst_stall", 32'(bus.stall_pipe), 32'd0);
        chk("t5_rst_we", 32'(bus.rf_we), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t5_restart_stall", 32'(bus.stall_pipe), 32'd0);
            cycle();
        end
        #1 chk("t5_force_again", 32'(bus.stall_pipe), 32'd1);
        cycle();
        clear_inputs();

        // 6: forwarding of the registered write.
        wb_write(5'd7, 32'h7777_7777);
        cycle();
        clear_inputs();
        bus.id_rs = 5'd7; bus.id_rt = 5'd0;
        #1 chk("t6_fwd_a", 32'(bus.fwd_a), 32'(exp_fwd));
        chk("t6_fwd_b_zero", 32'(bus.fwd_b), 32'd0);
        bus.id_rs = 5'd0; bus.id_rt = 5'd7;
        #1 chk("t6_fwd_a_zero", 32'(bus.fwd_a), 32'd0);
        chk("t6_fwd_b", 32'(bus.fwd_b), 32'(exp_fwd));
        cycle();
        chk("t6_fwd_b_nowe", 32'(bus.fwd_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
